// File: rtl/dmem_responder.sv
// Data-memory target for the rv32i core: aligned/extended reads, byte-lane writes, sticky illegal-access capture, access counters.
// Latency: reads combinational (same cycle); writes, error capture and counters commit on the rising edge ending the access.
// Backpressure: none; one access accepted every cycle, never stalls.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_zero_extnd_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  input  logic        err_clr_i,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic        r_err;
  logic [31:0] r_err_addr;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  logic [32:0]   w_diff;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_in_range;
  logic          w_misalign;
  logic          w_illegal;
  logic          w_legal;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;

  // 33-bit subtraction: bit 32 is the borrow, i.e. addr below BASE_ADDR.
  assign w_diff     = {1'b0, data_mem_addr_i} - {1'b0, BASE_ADDR};
  assign w_in_range = !w_diff[32] && (w_diff[31:AW+2] == '0);
  assign w_idx      = w_diff[AW+1:2];
  assign w_lane     = w_diff[1:0];

  always_comb begin
    w_misalign = 1'b0;
    case (data_mem_byte_en_i)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_lane[0];
      2'b11:   w_misalign = (w_lane != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_illegal = data_mem_req_i && (w_misalign || !w_in_range);
  assign w_legal   = data_mem_req_i && !w_illegal;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = data_mem_wr_data_i;
    case (data_mem_byte_en_i)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{data_mem_wr_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_mem_wr_data_i[15:0]}};
      end
      2'b11:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Storage is deliberately outside the reset domain; reset only gates writes.
  always_ff @(posedge clk) begin
    if (!reset && w_legal && data_mem_wr_i) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[8*w_lane +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ext = w_word;
    case (data_mem_byte_en_i)
      2'b00:   w_ext = {{24{!data_mem_zero_extnd_i && w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{!data_mem_zero_extnd_i && w_half[15]}}, w_half};
      default: w_ext = w_word;
    endcase
  end

  assign data_mem_rd_data_o = (w_legal && !data_mem_wr_i) ? w_ext : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
      r_rd_count <= 32'h0;
      r_wr_count <= 32'h0;
    end else begin
      // A fresh error outranks a same-cycle clear.
      if (w_illegal) begin
        if (!r_err || err_clr_i) begin
          r_err      <= 1'b1;
          r_err_addr <= data_mem_addr_i;
        end
      end else if (err_clr_i) begin
        r_err      <= 1'b0;
        r_err_addr <= 32'h0;
      end
      if (w_legal && data_mem_wr_i)  r_wr_count <= r_wr_count + 32'd1;
      if (w_legal && !data_mem_wr_i) r_rd_count <= r_rd_count + 32'd1;
    end
  end

  assign err_o      = r_err;
  assign err_addr_o = r_err_addr;
  assign rd_count_o = r_rd_count;
  assign wr_count_o = r_wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded directed bench for dmem_responder: read data checked by a monitor, status checked after each edge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  sz;
  logic        zx;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err_clr;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int tests = 0;
  int fails = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .data_mem_req_i(req), .data_mem_addr_i(addr), .data_mem_byte_en_i(sz),
    .data_mem_zero_extnd_i(zx), .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata),
    .data_mem_rd_data_o(rdata), .err_clr_i(err_clr), .err_o(err),
    .err_addr_o(err_addr), .rd_count_o(rd_cnt), .wr_count_o(wr_cnt)
  );

  // Monitor: every presented access is checked at the falling edge.
  always @(negedge clk) begin
    if (!reset && req) begin
      tests++;
      if (wr) begin
        if (rdata !== 32'h0) begin
          fails++;
          $display("FAIL wr_rd_zero addr=%h got=%h exp=00000000", addr, rdata);
        end
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read addr=%h got=%h", addr, rdata);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (rdata !== e) begin
          fails++;
          $display("FAIL %s got=%h exp=%h", n, rdata, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; leaves the bus idle at the following posedge+1.
  task automatic acc(input bit w, input logic [31:0] a, input logic [1:0] s, input bit z,
                     input logic [31:0] d, input logic [31:0] e, input bit legal, input string nm);
    req = 1'b1; wr = w; addr = a; sz = s; zx = z; wdata = d;
    if (!w) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk); #1;
    if (legal) begin
      if (w) exp_wr++; else exp_rd++;
    end
    req = 1'b0; wr = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; addr = '0; sz = 2'b11; zx = 1'b0; wr = 1'b0;
    wdata = '0; err_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_rd_cnt", rd_cnt, 32'h0);
    chk("rst_wr_cnt", wr_cnt, 32'h0);
    reset = 1'b0;

    acc(1, 32'h10, 2'b11, 0, 32'hDEAD_BEEF, 0, 1, "");
    acc(0, 32'h10, 2'b11, 0, 0, 32'hDEAD_BEEF, 1, "rd_word_10");
    chk("wr_cnt_1", wr_cnt, 32'd1);
    chk("rd_cnt_1", rd_cnt, 32'd1);

    acc(1, 32'h20, 2'b11, 0, 32'h1122_3344, 0, 1, "");
    acc(1, 32'h20, 2'b00, 0, 32'hFFFF_FF80, 0, 1, "");
    acc(1, 32'h21, 2'b00, 0, 32'h0000_007F, 0, 1, "");
    acc(0, 32'h20, 2'b00, 0, 0, 32'hFFFF_FF80, 1, "rd_b20_sx");
    acc(0, 32'h20, 2'b00, 1, 0, 32'h0000_0080, 1, "rd_b20_zx");
    acc(0, 32'h20, 2'b01, 0, 0, 32'h0000_7F80, 1, "rd_h20_sx");
    acc(0, 32'h20, 2'b11, 1, 0, 32'h1122_7F80, 1, "rd_w20");
    acc(0, 32'h21, 2'b00, 0, 0, 32'h0000_007F, 1, "rd_b21_sx");
    acc(0, 32'h22, 2'b01, 0, 0, 32'h0000_1122, 1, "rd_h22_sx");
    acc(1, 32'h22, 2'b01, 0, 32'h5555_F00D, 0, 1, "");
    acc(0, 32'h22, 2'b01, 0, 0, 32'hFFFF_F00D, 1, "rd_h22_sx2");
    acc(0, 32'h22, 2'b01, 1, 0, 32'h0000_F00D, 1, "rd_h22_zx");
    acc(0, 32'h23, 2'b00, 0, 0, 32'hFFFF_FFF0, 1, "rd_b23_sx");
    acc(0, 32'h20, 2'b11, 0, 0, 32'hF00D_7F80, 1, "rd_w20_b");

    acc(1, 32'h23, 2'b01, 0, 32'h0000_ABCD, 0, 0, "");
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_err_addr", err_addr, 32'h23);
    chk("mis_wr_cnt", wr_cnt, exp_wr);
    acc(0, 32'h20, 2'b11, 0, 0, 32'hF00D_7F80, 1, "rd_w20_unchanged");
    acc(0, 32'h1000, 2'b11, 0, 0, 32'h0, 0, "rd_oor");
    chk("oor_err_addr", err_addr, 32'h23);
    acc(0, 32'h12, 2'b11, 0, 0, 32'h0, 0, "rd_mis_word");
    chk("mis2_err_addr", err_addr, 32'h23);
    chk("rd_cnt_mid", rd_cnt, exp_rd);

    err_clr = 1'b1;
    acc(0, 32'h40, 2'b10, 0, 0, 32'h0, 0, "rd_reserved");
    chk("clr_new_err", {31'h0, err}, 32'h1);
    chk("clr_new_addr", err_addr, 32'h40);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_err", {31'h0, err}, 32'h0);
    chk("clr_err_addr", err_addr, 32'h0);

    acc(1, 32'h8, 2'b11, 0, 32'h1234_5678, 0, 1, "");
    acc(1, 32'hC, 2'b11, 0, 32'hCAFE_F00D, 0, 1, "");
    acc(0, 32'h41, 2'b11, 0, 0, 32'h0, 0, "rd_mis_41");
    chk("pre_rst_err", {31'h0, err}, 32'h1);
    chk("pre_rst_wr_cnt", wr_cnt, exp_wr);

    req = 1'b1; wr = 1'b1; addr = 32'hC; sz = 2'b11; wdata = 32'h1111_1111; reset = 1'b1;
    #1;
    chk("arst_err", {31'h0, err}, 32'h0);
    chk("arst_wr_cnt", wr_cnt, 32'h0);
    chk("arst_rd_cnt", rd_cnt, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0; wr = 1'b0;
    exp_wr = 0; exp_rd = 0;
    acc(0, 32'hC, 2'b11, 0, 0, 32'hCAFE_F00D, 1, "rd_C_after_rst");
    acc(0, 32'h8, 2'b11, 0, 0, 32'h1234_5678, 1, "rd_8_after_rst");
    chk("post_rst_rd_cnt", rd_cnt, 32'd2);
    chk("post_rst_wr_cnt", wr_cnt, 32'd0);
    chk("post_rst_err_addr", err_addr, 32'h0);

    force dut.r_wr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wr_count;
    chk("wrap_pre", wr_cnt, 32'hFFFF_FFFF);
    acc(1, 32'h30, 2'b11, 0, 32'h0BAD_CAFE, 0, 1, "");
    chk("wrap_wr_cnt", wr_cnt, 32'h0);
    acc(0, 32'h30, 2'b11, 0, 0, 32'h0BAD_CAFE, 1, "rd_30");

    @(posedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
